// File: rtl/buf_rd_arbiter_pkg.sv
// Shared buffer-RAM definitions: arbiter FSM states, read tag format, default RAM read latency.
// Used by the read arbiter, the RAM wrapper and the buffer handlers.
package buf_rd_arbiter_pkg;

    localparam int BUF_RD_LATENCY = 2;
    localparam int REQ_IDX_W      = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DRAIN
    } state_t;

    typedef struct packed {
        logic                 vld;
        logic [REQ_IDX_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/buf_rd_arbiter_rr_pick.sv
// Round-robin first-set-bit finder: searches upward from rr_ptr+1, wrapping modulo NUM_REQ.
// Purely combinational, zero latency, no flow control.
module rr_pick
    import buf_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [REQ_IDX_W-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]   pick
);

    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/buf_rd_arbiter.sv
// Lock-based round-robin arbiter for the buffer RAM read port; grant 1 cycle after req from idle,
// read data tagged back RD_LATENCY cycles after the strobe; a stuck owner is revoked after MAX_HOLD cycles.
module buf_rd_arbiter
    import buf_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = BUF_RD_LATENCY,
    parameter int MAX_HOLD   = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rd_en,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ADDR_W-1:0]         buf_rd_addr,
    input  logic [DATA_W-1:0]         buf_rd_data,
    output logic                      timeout,
    output logic [REQ_IDX_W-1:0]      timeout_id
);

    localparam int HOLD_W  = $clog2(MAX_HOLD + 1);
    localparam int DRAIN_W = $clog2(RD_LATENCY + 1);

    state_t               state, state_nxt;
    logic [REQ_IDX_W-1:0] owner, rr_ptr, pick_idx;
    logic [NUM_REQ-1:0]   pick;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [ADDR_W-1:0]    last_addr, own_addr;
    rd_tag_t              tag_pipe [RD_LATENCY];
    rd_tag_t              tag_out;
    logic                 own_req, own_rd_en, hold_max, release_now, timeout_hit, issue;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = REQ_IDX_W'(i);
        end
    end

    // gnt is the owner one-hot while busy, so it selects the owner's lines directly
    always_comb begin
        own_req   = 1'b0;
        own_rd_en = 1'b0;
        own_addr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                own_req   = req[i];
                own_rd_en = req_rd_en[i];
                own_addr  = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // A release coinciding with the hold limit counts as a normal release
    assign hold_max    = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign release_now = (state == ARB_BUSY) && (!own_req || hold_max);
    assign timeout_hit = (state == ARB_BUSY) && own_req && hold_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            gnt        <= '0;
            owner      <= '0;
            rr_ptr     <= REQ_IDX_W'(NUM_REQ - 1);
            hold_cnt   <= '0;
            drain_cnt  <= '0;
            last_addr  <= '0;
            timeout    <= 1'b0;
            timeout_id <= '0;
            for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            state       <= state_nxt;
            timeout     <= 1'b0;
            tag_pipe[0] <= {issue, owner};
            for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
            if (issue) last_addr <= own_addr;
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        gnt      <= pick;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                    end
                end
                ARB_BUSY: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (release_now) begin
                        gnt       <= '0;
                        rr_ptr    <= owner;
                        drain_cnt <= '0;
                    end
                    if (timeout_hit) begin
                        timeout    <= 1'b1;
                        timeout_id <= owner;
                    end
                end
                ARB_DRAIN: drain_cnt <= drain_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (|req) state_nxt = ARB_BUSY;
            ARB_BUSY:  if (release_now) state_nxt = ARB_DRAIN;
            ARB_DRAIN: if (drain_cnt == DRAIN_W'(RD_LATENCY - 1)) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    assign tag_out = tag_pipe[RD_LATENCY-1];
    assign rd_data = buf_rd_data;

    always_comb begin
        issue       = (state == ARB_BUSY) && own_rd_en;
        buf_rd_addr = issue ? own_addr : last_addr;
        rd_valid    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_valid[i] = tag_out.vld && (tag_out.id == REQ_IDX_W'(i));
        end
    end

endmodule

// File: doc/buf_rd_arbiter.md
# buf_rd_arbiter

Round-robin, lock-based arbiter that shares the single read port of the 2048×32 buffer RAM between up to NUM_REQ requesters, e.g. the settings data handler and the matrix input handlers. A requester holds the port for a whole multi-read transaction. The arbiter muxes addresses, tags each read, and returns a per-requester data-valid after the fixed RAM read latency. It sits between the buffer RAM and all its readers, and enforces a hold timeout so a hung requester cannot starve the others.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 11, RAM address width
- DATA_W, 32, RAM data width
- RD_LATENCY, 2, cycles from address presented to data valid on buf_rd_data
- MAX_HOLD, 4096, maximum cycles one grant may be held before forced release

Ports:
- clk  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester lock request; level, held for the whole transaction
- req_rd_en  input  NUM_REQ  per-requester read strobe; honoured only while granted
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; slice i belongs to requester i
- gnt  output  NUM_REQ  one-hot grant, registered
- rd_valid  output  NUM_REQ  one-hot pulse; buf_rd_data belongs to requester i in this cycle
- rd_data  output  DATA_W  buf_rd_data passed through, valid only when a rd_valid bit is set
- buf_rd_addr  output  ADDR_W  address to RAM
- buf_rd_data  input  DATA_W  RAM read data
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked
- timeout_id  output  3  requester index revoked, held until the next timeout

## Operation
- FSM states are ARB_IDLE, ARB_BUSY and ARB_DRAIN.
- ARB_IDLE:
  - When any req bit is set, grant the first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - Set gnt to that bit, load owner, clear hold_cnt, and go to ARB_BUSY.
- ARB_BUSY:
  - buf_rd_addr equals the req_addr slice of owner.
  - A read is issued when req_rd_en[owner] is high. It pushes tag {1, owner} into a RD_LATENCY-deep shift register.
  - req_rd_en from non-owners is ignored.
  - hold_cnt increments every cycle.
  - When req[owner] falls, or hold_cnt reaches MAX_HOLD-1: clear gnt, set rr_ptr to owner, and go to ARB_DRAIN.
  - On timeout, pulse timeout and load timeout_id with owner.
- ARB_DRAIN:
  - Stay for exactly RD_LATENCY cycles so in-flight reads retire, then go to ARB_IDLE.
  - No reads are issued in this state.
- Tag pipeline:
  - rd_valid[i] goes high when the output stage holds valid and tag == i.
  - Reads issued before release still return to the original owner during DRAIN.
- buf_rd_addr holds its last value when no read is issued.
- A requester that drops req and re-raises it is re-arbitrated fairly. It does not reclaim the port ahead of other pending requesters.

## Timing
- Reset values: gnt=0, rd_valid=0, timeout=0, timeout_id=0, buf_rd_addr=0, rd_data follows buf_rd_data, rr_ptr=NUM_REQ-1 (so requester 0 wins first), state=ARB_IDLE, tag pipeline cleared.
- Grant latency: req rises at cycle N, gnt is high at cycle N+1 (from ARB_IDLE). Worst case after a release is RD_LATENCY+2 cycles.
- Read latency: req_rd_en sampled at cycle N gives rd_valid at cycle N+RD_LATENCY.
- Release: req falls at cycle N, gnt is low at N+1, and the next grant can appear at N+RD_LATENCY+2.
- If req[owner] falls and the timeout triggers in the same cycle, treat it as a normal release with no timeout pulse.
- Requests that arrive simultaneously are resolved in the single ARB_IDLE cycle by round-robin order only.
- rst asserted mid-transaction clears the tag pipeline, so no rd_valid is produced for in-flight reads. All outputs take their reset values on the next edge.

## Structure
- Put state_t (ARB_IDLE, ARB_BUSY, ARB_DRAIN) and the default RD_LATENCY constant in the shared buffer-RAM package, which is also used by the RAM wrapper and the handlers.
- One natural sub-module is rr_pick: combinational round-robin first-set-bit finder with inputs req and rr_ptr and a one-hot output. It is reusable by the other arbiters.

## Test plan
- Single requester: req[1] high, read addresses 0 and 1 on consecutive cycles with RAM words 0x1 and 0x5. Expect gnt=0010 one cycle after req, rd_valid[1] at +2 cycles carrying 0x1 then 0x5, and rd_valid bits 0, 2 and 3 never set.
- Simultaneous req=1111 from reset, each holding for 3 cycles. Expect grant order 0,1,2,3, with no two gnt bits ever set and a gap of RD_LATENCY+1 cycles between grants.
- Release during in-flight reads: owner 2 reads addr 7 and then drops req the next cycle while req[3] is pending. Expect rd_valid[2] with data from addr 7 during ARB_DRAIN, and no rd_valid[3] before gnt[3].
- Timeout with MAX_HOLD=16: req[0] held forever while req[1] is pending. Expect gnt[0] to fall after 16 cycles, a timeout pulse with timeout_id=0, and gnt[1] to follow.
- Non-owner strobe: gnt[0] active while req_rd_en[2] toggles with addr 0x3FF. Expect buf_rd_addr never equal to 0x3FF and no rd_valid[2].
- Reset mid-read: assert rst one cycle after a granted read. Expect gnt=0 and no rd_valid afterwards.
